ccff_chain_programmer: RTL
==========================

// Module: ccff_chain_programmer
// PURPOSE
// - Drives the configuration-chain head (ccff_head) from host-supplied bitstream words.
// - Also observes the chain tail (ccff_tail) to verify what was loaded.
// - Programs CHAIN_LEN config bits into the fabric, MSB-first per word.
// - Optional verify pass: the host streams the same bitstream again. The bits leaving
//   ccff_tail must reproduce pass 1, checked by CRC-16 comparison.
// - Sits beside the fabric top, on the prog_clk domain.
// PARAMETERS
// - CHAIN_LEN  1024  total config bits in the ccff chain (>=1)
// - WORD_W     32    host word width (1..64)
// - CNT_W      $clog2(CHAIN_LEN+1)  bit-counter width (derived, not overridden)
// PORTS
// - prog_clk    in   1       programming clock; all logic on its rising edge
// - prog_reset  in   1       synchronous, active-high reset
// - start       in   1       1-cycle pulse: begin a programming sequence (ignored while busy)
// - verify      in   1       sampled with start: 1 = run the verify pass after load
// - s_data      in   WORD_W  bitstream word; bit WORD_W-1 is shifted first
// - s_valid     in   1       s_data valid
// - s_ready     out  1       word accepted when s_valid & s_ready
// - ccff_head   out  1       serial config bit into the chain
// - ccff_tail   in   1       serial bit out of the chain
// - shift_en    out  1       chain shifts at the end of a cycle with shift_en=1 (gates prog_clk via an external ICG)
// - busy        out  1       sequence in progress
// - done        out  1       1-cycle pulse at sequence end
// - verify_ok   out  1       sticky until the next start: CRC match (or verify=0)
// - verify_err  out  1       sticky until the next start: CRC mismatch
// BEHAVIOUR
// - Reset values: all outputs 0; state=IDLE; counters, CRCs and word buffer cleared.
// - FSM states and transitions:
//   - IDLE -> LOAD on start.
//   - LOAD -> VERIFY after CHAIN_LEN shifts, if verify.
//   - LOAD -> FINISH after CHAIN_LEN shifts, if !verify.
//   - VERIFY -> FINISH after CHAIN_LEN shifts.
//   - FINISH -> IDLE after 1 cycle (done=1 in FINISH).
// - start while busy is ignored. start clears verify_ok/verify_err.
// - Word buffer: one shift register (sreg) plus a bit index.
//   - s_ready=1 in LOAD/VERIFY when sreg is empty, or on the last used bit of sreg.
//     This gives back-to-back words with no bubble.
//   - s_ready=0 once all words of the current pass have been accepted.
// - Words per pass = ceil(CHAIN_LEN/WORD_W).
//   - In the final word only the top (CHAIN_LEN mod WORD_W) bits are shifted (all bits if the remainder is 0).
//   - The low remainder bits of the final word are discarded.
// - shift_en=1 only in cycles where sreg holds a valid bit; ccff_head = that bit.
// - Underrun: s_valid low with sreg empty -> shift_en=0, head holds 0, bit counter frozen (stall, no error).
// - Bit counter counts shift cycles 0..CHAIN_LEN-1 per pass.
//   - The pass ends in the cycle the CHAIN_LEN-th shift occurs.
//   - The counter resets to 0 on a pass change.
// - CRC: CRC-16-CCITT, poly 0x1021, init 0xFFFF, one bit per shift, MSB-first, no reflection or xor-out.
//   - crc_in accumulates ccff_head during LOAD shift cycles.
//   - crc_out accumulates ccff_tail during VERIFY shift cycles.
//   - The tail bit is sampled in the same cycle as shift_en.
// - Rationale for the comparison: in the VERIFY pass, the k-th tail bit equals the k-th head bit of LOAD.
// - FINISH (verify=1): verify_ok = (crc_in==crc_out), verify_err = !verify_ok.
// - FINISH (verify=0): verify_ok=1.
// - Latency: start -> first shift_en no earlier than 1 cycle later (word accepted in the cycle after start).
// - prog_reset mid-sequence: back to IDLE next edge.
//   - shift_en drops immediately on that edge; no done pulse; flags cleared.
//   - Chain contents are undefined; the host must restart.
// - busy=1 in LOAD, VERIFY and FINISH.
// STRUCTURE
// - Package ccff_prog_pkg holds:
//   - state enum {IDLE, LOAD, VERIFY, FINISH}
//   - CRC16_POLY=16'h1021, CRC16_INIT=16'hFFFF
//   - a words-per-pass helper function
// - One sub-module: ccff_crc16_serial (clr, en, din -> crc[15:0]), instantiated twice (crc_in, crc_out).
// - Top: FSM, word buffer/bit index, bit counter, flag registers.
// TESTING
// - Bench models the chain as a CHAIN_LEN shift register, clocked when shift_en=1.
// - Test 1, basic load:
//   - CHAIN_LEN=64, WORD_W=32, verify=0, words 0xDEADBEEF, 0x01234567, s_valid always high.
//   - Required: 64 consecutive shift_en cycles; model contents match MSB-first.
//   - Required: done pulse; verify_ok=1.
// - Test 2, partial last word:
//   - CHAIN_LEN=40, WORD_W=32, verify=1.
//   - Required: 2 words accepted per pass; only bits [31:24] of the second word shifted.
//   - Required: verify_ok=1 after 80 shift cycles.
// - Test 3, corrupted chain:
//   - As Test 2, but the model flips chain bit 17 between passes.
//   - Required: verify_err=1, verify_ok=0.
// - Test 4, stalls:
//   - s_valid randomly low 50% of cycles, CHAIN_LEN=64.
//   - Required: shift_en count=128 with verify=1; result identical to the no-stall run.
// - Test 5, reset and start-while-busy:
//   - prog_reset asserted at shift 30 of LOAD.
//   - Required: next cycle busy=0, shift_en=0, no done.
//   - Then issue start twice, 5 cycles apart.
//   - Required: second start ignored; exactly one done.

Source files
------------

// File: rtl/ccff_chain_programmer_pkg.sv
`default_nettype none
// ============================================================================
// Module : ccff_prog_pkg
// Brief  : Shared types and constants for the configuration-chain programmer:
//          sequencer state encoding, CRC-16-CCITT constants and a helper that
//          sizes a programming pass in host words.
// Rev    : 1.0
// ============================================================================
package ccff_prog_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // Host words needed to cover chain_len bits (ceiling division).
  function automatic int words_per_pass(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ccff_chain_programmer_if.sv
`default_nettype none
// ============================================================================
// Module : ccff_chain_programmer_if
// Brief  : Host / chain-side signal bundle of the configuration-chain
//          programmer.
//          master : host side (drives start, verify, s_data, s_valid and
//                   returns the chain tail bit)
//          slave  : programmer side (drives s_ready, ccff_head, shift_en,
//                   busy, done, verify_ok, verify_err)
// Rev    : 1.0
// ============================================================================
interface ccff_chain_programmer_if #(
  parameter int WORD_W = 32
);
  logic              start;
  logic              verify;
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              ccff_head;
  logic              ccff_tail;
  logic              shift_en;
  logic              busy;
  logic              done;
  logic              verify_ok;
  logic              verify_err;

  modport master (
    output start, verify, s_data, s_valid, ccff_tail,
    input  s_ready, ccff_head, shift_en, busy, done, verify_ok, verify_err
  );

  modport slave (
    input  start, verify, s_data, s_valid, ccff_tail,
    output s_ready, ccff_head, shift_en, busy, done, verify_ok, verify_err
  );
endinterface
`default_nettype wire

// File: rtl/ccff_chain_programmer_crc16.sv
`default_nettype none
// ============================================================================
// Module : ccff_crc16_serial
// Brief  : Bit-serial CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first,
//          no reflection, no final xor). One bit absorbed per enabled cycle.
//          clk    in  clock
//          rst    in  synchronous active-high reset (CRC back to init)
//          i_clr  in  restart the CRC at init
//          i_en   in  absorb i_din this cycle
//          i_din  in  serial data bit
//          o_crc  out running CRC value
// Rev    : 1.0
// ============================================================================
module ccff_crc16_serial
  import ccff_prog_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        i_clr,
  input  wire logic        i_en,
  input  wire logic        i_din,
  output logic [15:0]      o_crc
);

  logic [15:0] r_crc;
  logic        w_fb;

  assign w_fb  = r_crc[15] ^ i_din;
  assign o_crc = r_crc;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_crc <= CRC16_INIT;
    end else if (i_en) begin
      r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? CRC16_POLY : 16'h0000);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ccff_chain_programmer.sv
`default_nettype none
// ============================================================================
// Module : ccff_chain_programmer
// Brief  : Streams host bitstream words into the fabric configuration chain
//          (MSB of each word first) and optionally re-streams them while
//          capturing the chain tail, comparing CRC-16 of both passes.
//          prog_clk    in  programming clock (rising edge)
//          prog_reset  in  synchronous active-high reset
//          bus         slave side of ccff_chain_programmer_if:
//            start/verify, s_data/s_valid/s_ready word stream,
//            ccff_head/ccff_tail/shift_en chain interface,
//            busy/done/verify_ok/verify_err status.
// Rev    : 1.0
// ============================================================================
module ccff_chain_programmer
  import ccff_prog_pkg::*;
#(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 32
) (
  input  wire logic               prog_clk,
  input  wire logic               prog_reset,
  ccff_chain_programmer_if.slave  bus
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int NB_W  = $clog2(WORD_W + 1);
  localparam int WPP   = words_per_pass(CHAIN_LEN, WORD_W);
  localparam int REM   = CHAIN_LEN % WORD_W;

  localparam logic [NB_W-1:0]  c_full_bits  = NB_W'(WORD_W);
  localparam logic [NB_W-1:0]  c_last_bits  = NB_W'((REM == 0) ? WORD_W : REM);
  localparam logic [NB_W-1:0]  c_one_bit    = NB_W'(1);
  localparam logic [CNT_W-1:0] c_last_shift = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] c_wpp        = CNT_W'(WPP);
  localparam logic [CNT_W-1:0] c_last_word  = CNT_W'(WPP - 1);

  state_t            r_state;
  state_t            w_next_state;

  logic [WORD_W-1:0] r_sreg;
  logic [NB_W-1:0]   r_nbits;    // valid bits still waiting in r_sreg
  logic [CNT_W-1:0]  r_bitcnt;   // shifts done in the current pass
  logic [CNT_W-1:0]  r_words;    // words accepted in the current pass
  logic              r_verify;
  logic              r_ok;
  logic              r_err;

  logic              w_active;
  logic              w_have_bit;
  logic              w_ready;
  logic              w_accept;
  logic              w_pass_end;
  logic              w_start;
  logic              w_ok_now;
  logic [15:0]       w_crc_in;
  logic [15:0]       w_crc_out;

  assign w_active   = (r_state == ST_LOAD) || (r_state == ST_VERIFY);
  assign w_have_bit = w_active && (r_nbits != '0);
  // Refill while the buffer is empty or its last bit is leaving, so a new
  // word lands exactly when the previous one runs out (no bubble).
  assign w_ready    = w_active && (r_words != c_wpp) && (r_nbits <= c_one_bit);
  assign w_accept   = w_ready && bus.s_valid;
  assign w_pass_end = w_have_bit && (r_bitcnt == c_last_shift);
  assign w_start    = (r_state == ST_IDLE) && bus.start;
  assign w_ok_now   = r_verify ? (w_crc_in == w_crc_out) : 1'b1;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (bus.start)  w_next_state = ST_LOAD;
      ST_LOAD:   if (w_pass_end) w_next_state = r_verify ? ST_VERIFY : ST_FINISH;
      ST_VERIFY: if (w_pass_end) w_next_state = ST_FINISH;
      ST_FINISH: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    bus.busy       = (r_state != ST_IDLE);
    bus.s_ready    = w_ready;
    bus.shift_en   = w_have_bit;
    bus.ccff_head  = w_have_bit && r_sreg[WORD_W-1];
    bus.done       = (r_state == ST_FINISH);
    // The result is visible alongside done and held in r_ok/r_err afterwards.
    bus.verify_ok  = r_ok  || ((r_state == ST_FINISH) &&  w_ok_now);
    bus.verify_err = r_err || ((r_state == ST_FINISH) && !w_ok_now);
  end

  // --------------------------------------------------------------------------
  // Word buffer, bit counter and result flags
  // --------------------------------------------------------------------------
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_sreg   <= '0;
      r_nbits  <= '0;
      r_bitcnt <= '0;
      r_words  <= '0;
      r_verify <= 1'b0;
      r_ok     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_start) begin
        r_verify <= bus.verify;
        r_ok     <= 1'b0;
        r_err    <= 1'b0;
        r_bitcnt <= '0;
        r_words  <= '0;
        r_nbits  <= '0;
      end

      // A refill on the last-bit cycle replaces the shift: that bit is
      // already on ccff_head this cycle. The final word of a pass only
      // carries its top bits; the remainder is simply left behind.
      if (w_accept) begin
        r_sreg  <= bus.s_data;
        r_nbits <= (r_words == c_last_word) ? c_last_bits : c_full_bits;
        r_words <= r_words + 1'b1;
      end else if (w_have_bit) begin
        r_sreg  <= r_sreg << 1;
        r_nbits <= r_nbits - 1'b1;
      end

      if (w_have_bit) begin
        r_bitcnt <= w_pass_end ? '0 : (r_bitcnt + 1'b1);
      end

      if (w_pass_end) begin
        r_words <= '0;
      end

      if (r_state == ST_FINISH) begin
        r_ok  <= w_ok_now;
        r_err <= !w_ok_now;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pass CRCs: head bits while loading, tail bits while verifying
  // --------------------------------------------------------------------------
  ccff_crc16_serial u_crc_in (
    .clk   (prog_clk),
    .rst   (prog_reset),
    .i_clr (w_start),
    .i_en  ((r_state == ST_LOAD) && w_have_bit),
    .i_din (bus.ccff_head),
    .o_crc (w_crc_in)
  );

  ccff_crc16_serial u_crc_out (
    .clk   (prog_clk),
    .rst   (prog_reset),
    .i_clr (w_start),
    .i_en  ((r_state == ST_VERIFY) && w_have_bit),
    .i_din (bus.ccff_tail),
    .o_crc (w_crc_out)
  );

endmodule
`default_nettype wire
